// File: rtl/analog_status_poller.sv
// ----------------------------------------------------------------------------
// analog_status_poller
//
// APB master that sweeps the four 32-bit status words of the analog status
// array at BASE_ADDR + 4n. It keeps a local snapshot of each word, flags
// per-word changes and raises a level interrupt. Only reads are issued.
//
// Ports:
//   clk_in, reset_n   clock, asynchronous active-low reset
//   PADDR..PSTRB      APB master request signals (reads only)
//   PRDATA, PREADY,
//   PSLVERR           APB completer response
//   enable_i          polling enable, sampled at sweep boundaries only
//   irq_mask_i        per-word change interrupt enable
//   clear_i           W1C pulse: [3:0] change flags, [4] error flag
//   snapshot_o        last good value of word n on bits [32n+31:32n]
//   change_o          sticky per-word change flags
//   err_o             sticky error flag (PSLVERR or PREADY timeout)
//   irq_o             registered level interrupt
// ----------------------------------------------------------------------------
module analog_status_poller #(
    parameter logic [11:0] BASE_ADDR      = 12'h000,
    parameter int unsigned POLL_INTERVAL  = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         clk_in,
    input  logic         reset_n,
    // APB master port
    output logic [11:0]  PADDR,
    output logic         PSEL,
    output logic         PENABLE,
    output logic         PWRITE,
    output logic [31:0]  PWDATA,
    output logic [3:0]   PSTRB,
    input  logic [31:0]  PRDATA,
    input  logic         PREADY,
    input  logic         PSLVERR,
    // Control and status
    input  logic         enable_i,
    input  logic [3:0]   irq_mask_i,
    input  logic [4:0]   clear_i,
    output logic [127:0] snapshot_o,
    output logic [3:0]   change_o,
    output logic         err_o,
    output logic         irq_o
);

    // ------------------------------------------------------------------------
    // Counter widths and constants
    // ------------------------------------------------------------------------
    localparam int unsigned IW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    // WAIT counts down from here to 0, giving POLL_INTERVAL idle cycles.
    localparam logic [IW-1:0] INTERVAL_LOAD = IW'(POLL_INTERVAL - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST  = TW'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StSetup  = 3'd1;
    localparam logic [2:0] StAccess = 3'd2;
    localparam logic [2:0] StGap    = 3'd3;
    localparam logic [2:0] StWait   = 3'd4;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]        state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [11:0]       paddr_q, paddr_d;
    logic              first_q, first_d;
    logic [IW-1:0]     wait_q, wait_d;
    logic [TW-1:0]     to_q, to_d;
    logic [3:0][31:0]  snap_q, snap_d;
    logic [3:0]        change_q, change_d;
    logic              err_q, err_d;
    logic              irq_q, irq_d;

    function automatic logic [11:0] word_addr(input logic [1:0] idx);
        return BASE_ADDR + {8'h00, idx, 2'b00};
    endfunction

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        paddr_d  = paddr_q;
        first_d  = first_q;
        wait_d   = wait_q;
        to_d     = to_q;
        snap_d   = snap_q;
        // Clears apply first so that a set in the same cycle overrides them.
        change_d = change_q & ~clear_i[3:0];
        err_d    = err_q & ~clear_i[4];

        case (state_q)
            StIdle: begin
                if (enable_i) begin
                    state_d = StSetup;
                    idx_d   = 2'd0;
                    paddr_d = word_addr(2'd0);
                end
            end

            StSetup: begin
                state_d = StAccess;
                to_d    = '0;
            end

            StAccess: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        err_d = 1'b1;
                    end else begin
                        // The first sweep only seeds the snapshot.
                        if (!first_q && (PRDATA != snap_q[idx_q])) begin
                            change_d[idx_q] = 1'b1;
                        end
                        snap_d[idx_q] = PRDATA;
                    end
                    state_d = StGap;
                end else if (to_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = StGap;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end

            // One idle bus cycle so the completer can drop PREADY.
            StGap: begin
                if (idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    paddr_d = word_addr(idx_q + 2'd1);
                    state_d = StSetup;
                end else begin
                    first_d = 1'b0;
                    wait_d  = INTERVAL_LOAD;
                    state_d = StWait;
                end
            end

            // enable_i is only honoured here, so a sweep always completes.
            StWait: begin
                if (wait_q == '0) begin
                    if (enable_i) begin
                        state_d = StSetup;
                        idx_d   = 2'd0;
                        paddr_d = word_addr(2'd0);
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        irq_d = (|(change_q & irq_mask_i)) | err_q;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            idx_q    <= 2'd0;
            paddr_q  <= 12'h000;
            first_q  <= 1'b1;
            wait_q   <= '0;
            to_q     <= '0;
            snap_q   <= '0;
            change_q <= 4'h0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            paddr_q  <= paddr_d;
            first_q  <= first_d;
            wait_q   <= wait_d;
            to_q     <= to_d;
            snap_q   <= snap_d;
            change_q <= change_d;
            err_q    <= err_d;
            irq_q    <= irq_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Decoded straight from state so reset drops PSEL/PENABLE asynchronously.
    assign PSEL       = (state_q == StSetup) || (state_q == StAccess);
    assign PENABLE    = (state_q == StAccess);
    assign PADDR      = paddr_q;
    assign PWRITE     = 1'b0;
    assign PWDATA     = 32'h0000_0000;
    assign PSTRB      = 4'h0;

    assign snapshot_o = snap_q;
    assign change_o   = change_q;
    assign err_o      = err_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_analog_status_poller.sv
// ----------------------------------------------------------------------------
// Testbench for analog_status_poller. A small APB completer model answers the
// reads; the stimulus process pushes one expected entry per word read into a
// scoreboard and a monitor pops and compares at the end of every transfer.
// ----------------------------------------------------------------------------
module tb_analog_status_poller;

    localparam int unsigned POLL     = 8;
    localparam int unsigned TIMEOUT  = 16;

    logic         clk_in = 1'b0;
    logic         reset_n;
    logic [11:0]  PADDR;
    logic         PSEL, PENABLE, PWRITE;
    logic [31:0]  PWDATA;
    logic [3:0]   PSTRB;
    logic [31:0]  PRDATA;
    logic         PREADY, PSLVERR;
    logic         enable_i;
    logic [3:0]   irq_mask_i;
    logic [4:0]   clear_i;
    logic [127:0] snapshot_o;
    logic [3:0]   change_o;
    logic         err_o, irq_o;

    always #5 clk_in = ~clk_in;

    analog_status_poller #(
        .BASE_ADDR      (12'h000),
        .POLL_INTERVAL  (POLL),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .PADDR      (PADDR),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PSTRB      (PSTRB),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
        .enable_i   (enable_i),
        .irq_mask_i (irq_mask_i),
        .clear_i    (clear_i),
        .snapshot_o (snapshot_o),
        .change_o   (change_o),
        .err_o      (err_o),
        .irq_o      (irq_o)
    );

    // ------------------------------------------------------------------------
    // Completer model: zero wait states unless a word is set to hang.
    // ------------------------------------------------------------------------
    logic [3:0][31:0] slave_data;
    logic [3:0]       slave_hang;
    logic [3:0]       slave_err;
    logic [1:0]       sidx;

    always_comb begin
        sidx    = PADDR[3:2];
        PRDATA  = slave_data[sidx];
        PREADY  = PSEL && PENABLE && !slave_hang[sidx];
        PSLVERR = PSEL && PENABLE && slave_err[sidx];
    end

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [11:0]  addr;
        logic [127:0] snap;
        logic [3:0]   change;
        logic         err;
        int           acc;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [3:0][31:0] exp_snap;
    logic [3:0]       exp_change;
    logic             exp_err;
    logic             exp_first;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_snap   = '0;
        exp_change = 4'h0;
        exp_err    = 1'b0;
        exp_first  = 1'b1;
    endtask

    // Expected outcome of one full sweep given the current completer setup.
    task automatic push_sweep();
        exp_t e;
        for (int n = 0; n < 4; n++) begin
            if (slave_hang[n] || slave_err[n]) begin
                exp_err = 1'b1;
            end else begin
                if (!exp_first && slave_data[n] != exp_snap[n]) exp_change[n] = 1'b1;
                exp_snap[n] = slave_data[n];
            end
            e.addr   = 12'(4 * n);
            e.snap   = exp_snap;
            e.change = exp_change;
            e.err    = exp_err;
            e.acc    = slave_hang[n] ? TIMEOUT : 1;
            sb_q.push_back(e);
        end
        exp_first = 1'b0;
    endtask

    // Monitor: a transfer ends on the first non-ACCESS cycle after ACCESS.
    logic prev_acc = 1'b0;
    int   acc_cnt  = 0;

    always @(negedge clk_in) begin
        exp_t e;
        if (!reset_n) begin
            prev_acc = 1'b0;
            acc_cnt  = 0;
        end else begin
            if (PSEL && !PENABLE) check("write_side_zero", {PWRITE, PSTRB, PWDATA}, '0);
            if (PSEL && PENABLE) begin
                acc_cnt++;
            end else if (prev_acc) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_transfer", {PADDR}, 12'hfff);
                end else begin
                    e = sb_q.pop_front();
                    check("paddr", PADDR, e.addr);
                    check("snapshot", snapshot_o, e.snap);
                    check("change", change_o, e.change);
                    check("err", err_o, e.err);
                    check("access_cycles", acc_cnt, e.acc);
                end
                acc_cnt = 0;
            end
            prev_acc = PSEL && PENABLE;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change 2 time units after the falling edge)
    // ------------------------------------------------------------------------
    task automatic step();
        @(negedge clk_in);
        #2;
    endtask

    task automatic wait_empty(input int max_cycles);
        int n = 0;
        while (sb_q.size() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        check("scoreboard_drained", sb_q.size() == 0, 1'b1);
    endtask

    task automatic wait_access(input logic [11:0] addr, input int max_cycles);
        int n = 0;
        while (!(PSEL && PENABLE && PADDR == addr) && n < max_cycles) begin
            step();
            n++;
        end
        check("access_reached", PSEL && PENABLE && PADDR == addr, 1'b1);
    endtask

    task automatic pulse_clear(input logic [4:0] mask);
        clear_i = mask;
        step();
        clear_i = 5'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int psel_seen;
        int n;
        reset_n    = 1'b0;
        enable_i   = 1'b0;
        irq_mask_i = 4'h0;
        clear_i    = 5'h00;
        slave_data = '0;
        slave_hang = 4'h0;
        slave_err  = 4'h0;
        model_reset();

        // Reset state
        repeat (3) step();
        check("rst_psel_penable", {PSEL, PENABLE}, 2'b00);
        check("rst_paddr", PADDR, 12'h000);
        check("rst_flags", {snapshot_o, change_o, err_o, irq_o}, '0);
        reset_n = 1'b1;

        // Sweep 1: first sweep only loads snapshots
        slave_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        push_sweep();
        enable_i = 1'b1;
        wait_empty(200);
        check("s1_snapshot", snapshot_o, 128'h000000A3_000000A2_000000A1_000000A0);
        check("s1_change", change_o, 4'h0);
        step();
        check("s1_irq", irq_o, 1'b0);

        // Sweep 2: word 2 changes, irq follows one cycle after the flag
        slave_data[2] = 32'hFF;
        irq_mask_i    = 4'b0100;
        push_sweep();
        n = 0;
        while (!change_o[2] && n < 100) begin
            step();
            n++;
        end
        check("s2_change_seen", change_o, 4'b0100);
        check("s2_irq_lags", irq_o, 1'b0);
        step();
        check("s2_irq_set", irq_o, 1'b1);
        wait_empty(200);
        pulse_clear(5'b00100);
        exp_change[2] = 1'b0;
        check("s2_change_cleared", change_o, 4'h0);
        step();
        check("s2_irq_cleared", irq_o, 1'b0);

        // Sweep 3: word 2 never answers -> timeout, snapshot kept
        slave_hang[2] = 1'b1;
        slave_data[2] = 32'h55;
        push_sweep();
        wait_empty(300);
        check("s3_err", err_o, 1'b1);
        check("s3_irq", irq_o, 1'b1);
        check("s3_word2_kept", snapshot_o[95:64], 32'hFF);
        slave_hang[2] = 1'b0;
        slave_data[2] = 32'hFF;
        pulse_clear(5'b10000);
        exp_err = 1'b0;
        check("s3_err_cleared", err_o, 1'b0);
        step();
        check("s3_irq_cleared", irq_o, 1'b0);

        // Sweep 4: PSLVERR on 0x4 with a simultaneous err clear
        slave_err[1]  = 1'b1;
        slave_data[1] = 32'h77;
        push_sweep();
        wait_access(12'h004, 100);
        pulse_clear(5'b10000);
        check("s4_set_beats_clear", err_o, 1'b1);
        wait_empty(200);
        check("s4_word1_kept", snapshot_o[63:32], 32'hA1);
        slave_err[1] = 1'b0;
        pulse_clear(5'b10000);
        exp_err = 1'b0;
        check("s4_err_cleared", err_o, 1'b0);

        // Sweep 5: enable drops during the 0x4 read; sweep still completes
        push_sweep();
        wait_access(12'h004, 100);
        enable_i = 1'b0;
        wait_empty(200);
        psel_seen = 0;
        for (int i = 0; i < 3 * POLL + 10; i++) begin
            step();
            if (PSEL) psel_seen++;
        end
        check("s5_no_more_psel", psel_seen, 0);

        // Reset during ACCESS, then a first sweep that sets no change flags
        slave_data = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        enable_i   = 1'b1;
        wait_access(12'h000, 20);
        #1 reset_n = 1'b0;
        #1;
        check("async_reset_drop", {PSEL, PENABLE}, 2'b00);
        step();
        check("reset_flags", {snapshot_o, change_o, err_o, irq_o}, '0);
        model_reset();
        reset_n = 1'b1;
        push_sweep();
        wait_empty(200);
        check("post_reset_change", change_o, 4'h0);
        check("post_reset_snapshot", snapshot_o, 128'h000000B3_000000B2_000000B1_000000B0);
        step();
        check("post_reset_irq", irq_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
